// File: rtl/mul_pkg.sv
// mul_pkg: shared state encoding and default width for the shift-and-add multiply-accumulate unit
package mul_pkg;
  localparam int MUL_WIDTH = 8;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/mul_add_dp.sv
// mul_add_dp: multiplicand/multiplier/accumulator registers and the accumulate adder
module mul_add_dp
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   c,
  output logic [2*WIDTH-1:0] acc_out
);
  logic [2*WIDTH-1:0] mcand, acc;
  logic [WIDTH-1:0]   mplier;
  // acc_out is the post-step sum so the final step can be captured without an extra cycle
  assign acc_out = acc + (mplier[0] ? mcand : '0);
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (load) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      acc    <= {{WIDTH{1'b0}}, c};
    end else if (step) begin
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      acc    <= acc_out;
    end
  end
endmodule

// File: rtl/mul_add_seq.sv
// mul_add_seq: fixed-latency sequential result = a*b + c with start/busy/done handshake
module mul_add_seq
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   c,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  state_t             state;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc_out;
  logic               load, step, last;
  assign busy = state == RUN;
  assign done = state == DONE;
  assign load = start && (state == IDLE || state == DONE);
  assign step = busy;
  assign last = count == CW'(WIDTH - 1);
  mul_add_dp #(.WIDTH(WIDTH)) u_dp (
    .clk(clk), .reset(reset), .load(load), .step(step),
    .a(a), .b(b), .c(c), .acc_out(acc_out)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= start ? RUN : IDLE;
          count <= '0;
        end
        RUN: begin
          count <= count + 1'b1;
          if (last) begin
            result <= acc_out;
            state  <= DONE;
          end
        end
        default: begin
          state <= start ? RUN : IDLE;
          count <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mul_add_seq.sv
// tb_mul_add_seq: directed and random checks of mul_add_seq latency, handshake and arithmetic
module tb_mul_add_seq;
  logic        clk = 0, reset = 0, start = 0;
  logic [7:0]  a = 0, b = 0, c = 0;
  logic        busy, done;
  logic [15:0] result;
  int tests = 0, fails = 0;

  mul_add_seq #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .c(c),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Pulse start from IDLE/DONE, count busy cycles and stop in the done cycle.
  task automatic run_op(input logic [7:0] aa, bb, cc, output logic [15:0] res,
                        output int nbusy, output bit got);
    a = aa; b = bb; c = cc; start = 1;
    tick();
    start = 0;
    nbusy = 0; got = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin got = 1; break; end
      if (busy) nbusy++;
      tick();
    end
    res = result;
  endtask

  task automatic check_op(input string name, input logic [7:0] aa, bb, cc,
                          input logic [15:0] exp);
    logic [15:0] r; int n; bit g;
    run_op(aa, bb, cc, r, n, g);
    tests++;
    if (!g) begin fails++; $display("FAIL %s: done never seen", name); end
    tests++;
    if (n !== 8) begin fails++; $display("FAIL %s busy cycles: got %0d expected 8", name, n); end
    tests++;
    if (r !== exp) begin fails++; $display("FAIL %s result: got %0d expected %0d", name, r, exp); end
  endtask

  task automatic test_reset();
    reset = 1; start = 1; a = 5; b = 5; c = 5;
    tick(); tick();
    start = 0; reset = 0;
    tests++;
    if ({busy, done, result} !== 18'd0) begin
      fails++; $display("FAIL reset: busy=%0b done=%0b result=%0d expected 0 0 0", busy, done, result);
    end
    tick();
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_wins_start: busy=%0b expected 0", busy); end
  endtask

  task automatic test_basic();
    check_op("13*7+5", 8'd13, 8'd7, 8'd5, 16'd96);
    check_op("255*255+255", 8'd255, 8'd255, 8'd255, 16'hFF00);
    check_op("200*0+17", 8'd200, 8'd0, 8'd17, 16'd17);
    check_op("0*99+0", 8'd0, 8'd99, 8'd0, 16'd0);
  endtask

  task automatic test_start_ignored();
    int n; bit g;
    a = 13; b = 7; c = 5; start = 1;
    tick();
    a = 1; b = 1; c = 1;
    n = 0; g = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 6) start = 0;
      if (done) begin g = 1; break; end
      if (busy) n++;
      tick();
    end
    start = 0;
    tests++;
    if (!g || n !== 8 || result !== 16'd96) begin
      fails++; $display("FAIL start_ignored: done=%0b busy=%0d result=%0d expected 1 8 96", g, n, result);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int n; bit g;
    a = 10; b = 10; c = 1; start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 20 && !done; i++) tick();
    tests++;
    if (done !== 1'b1 || result !== 16'd101) begin
      fails++; $display("FAIL b2b first: done=%0b result=%0d expected 1 101", done, result);
    end
    a = 3; b = 4; c = 0; start = 1;
    tick();
    start = 0;
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL b2b restart: busy=%0b expected 1", busy); end
    n = 0; g = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin g = 1; break; end
      if (busy) n++;
      tick();
    end
    tests++;
    if (!g || n !== 8 || result !== 16'd12) begin
      fails++; $display("FAIL b2b second: done=%0b busy=%0d result=%0d expected 1 8 12", g, n, result);
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    bit seen;
    a = 9; b = 9; c = 0; start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 3; i++) tick();
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL abort pre: busy=%0b expected 1", busy); end
    reset = 1;
    tick();
    reset = 0;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 16'd0) begin
      fails++; $display("FAIL abort: busy=%0b done=%0b result=%0d expected 0 0 0", busy, done, result);
    end
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (done) seen = 1;
      tick();
    end
    tests++;
    if (seen) begin fails++; $display("FAIL abort no_done: done seen after abort"); end
  endtask

  task automatic test_random();
    logic [7:0] ra, rb, rc; logic [15:0] r, exp; int n; bit g; int bad = 0;
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 8'($urandom);
      exp = 16'(ra) * 16'(rb) + 16'(rc);
      run_op(ra, rb, rc, r, n, g);
      tests++;
      if (!g || n !== 8 || r !== exp) begin
        fails++; bad++;
        if (bad <= 5) $display("FAIL random %0d*%0d+%0d: got %0d busy=%0d expected %0d busy=8", ra, rb, rc, r, n, exp);
      end
    end
  endtask

  task automatic test_div_cross();
    logic [7:0] x, d, q, rm; logic [15:0] r; int n; bit g;
    for (int i = 0; i < 50; i++) begin
      x = 8'($urandom); d = 8'($urandom_range(1, 255));
      q = x / d; rm = x % d;
      run_op(q, d, rm, r, n, g);
      tests++;
      if (!g || r !== {8'd0, x}) begin
        fails++; $display("FAIL div_cross %0d/%0d: got %0d expected %0d", x, d, r, x);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    test_div_cross();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
